// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants, BCD codes and capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_INVALID = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Strict segment-pattern to BCD decode; anything not an exact digit or blank is invalid.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  // Exact-match lookup against the shared pattern constants
  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b1;
    case (seg)
      SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
      SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
      SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
      SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
      SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
      SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
      SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
      SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
      SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
      SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed 7-segment bus, debounces each digit, and emits whole frames.
//
//  state  | meaning
//  IDLE   | no valid one-hot strobe present
//  SETTLE | valid strobe seen, counting cycles of unchanged digit_en/seg_in
//  HOLD   | digit captured, waiting for digit_en to change
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [6:0]              seg_in,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    out_valid,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  cap_state_t state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]   prev_en;
  logic [6:0]              prev_seg;
  logic                    strobe_ok, en_changed, changed, capture;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              dec_bcd;
  logic                    dec_err;
  logic [NUM_DIGITS-1:0]   seen, seen_m;
  logic [4*NUM_DIGITS-1:0] stage_bcd, stage_bcd_m;
  logic [NUM_DIGITS-1:0]   stage_err, stage_err_m;
  logic                    frame_done, accept, load, drop;

  seg7_pattern_decode u_decode (
    .seg (seg_in),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Strobe qualification and change detection against last cycle's bus
  always_comb begin
    strobe_ok  = (digit_en != '0) &&
                 ((digit_en & (digit_en - NUM_DIGITS'(1))) == '0);
    en_changed = (digit_en != prev_en);
    changed    = en_changed || (seg_in != prev_seg);
  end

  // One-hot strobe to digit index (only meaningful when strobe_ok)
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_en[i]) idx = IDX_W'(i);
    end
  end

  // Capture FSM next-state; the capture fires in the cycle the count reaches its target
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (strobe_ok) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = strobe_ok ? SETTLE : IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (en_changed) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = strobe_ok ? SETTLE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (state_nxt == SETTLE && cnt_nxt == CNT_MAX) begin
      capture   = 1'b1;
      state_nxt = HOLD;
    end
  end

  // Merge the captured digit into staging and decide frame delivery
  always_comb begin
    stage_bcd_m = stage_bcd;
    stage_err_m = stage_err;
    seen_m      = seen;
    if (capture) begin
      stage_bcd_m[{idx, 2'b00} +: 4] = dec_bcd;
      stage_err_m[idx]               = dec_err;
      seen_m[idx]                    = 1'b1;
    end
    frame_done = capture && (seen_m == ALL_SEEN);
    accept     = out_valid && out_ready;
    load       = frame_done && (!out_valid || out_ready);
    drop       = frame_done && out_valid && !out_ready;
  end

  // FSM, counter and bus history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_en  <= '0;
      prev_seg <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      prev_en  <= digit_en;
      prev_seg <= seg_in;
    end
  end

  // Staging, output frame and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= '0;
      stage_bcd <= '0;
      stage_err <= '0;
      bcd_out   <= '0;
      digit_err <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      seen      <= frame_done ? '0 : seen_m;
      stage_bcd <= stage_bcd_m;
      stage_err <= stage_err_m;
      if (load) begin
        bcd_out   <= stage_bcd_m;
        digit_err <= stage_err_m;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=3).
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_en;
  logic [6:0]  seg_in;
  logic        out_ready;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        out_valid;
  logic        overflow;

  frame_t sb[$];
  int n_tests   = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  int v0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_en  (digit_en),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .digit_err (digit_err),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    digit_en = 4'(1 << d);
    seg_in   = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    digit_en = '0;
    seg_in   = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] b, input logic [3:0] e);
    frame_t f;
    f.bcd = b;
    f.err = e;
    sb.push_back(f);
  endtask

  // Monitor: every accepted frame must match the oldest expected frame
  always @(negedge clk) begin
    frame_t e;
    if (!rst) begin
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got bcd=%h err=%b expected no frame", bcd_out, digit_err);
        end else begin
          e = sb.pop_front();
          if (bcd_out !== e.bcd || digit_err !== e.err) begin
            n_fail++;
            $display("FAIL frame: got bcd=%h err=%b expected bcd=%h err=%b",
                     bcd_out, digit_err, e.bcd, e.err);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; digit_en = '0; seg_in = '0; out_ready = 1'b1;
    #12;
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_err", 32'(digit_err), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    blank(2);

    // 1: basic scan, one-cycle valid pulse
    v0 = valid_cnt;
    push(16'h3210, 4'b0000);
    show(0, SEG_0, 5); show(1, SEG_1, 5); show(2, SEG_2, 5); show(3, SEG_3, 5);
    blank(4);
    check("t1_valid_pulse_len", 32'(valid_cnt - v0), 32'd1);

    // 2: invalid pattern and blank digit
    push(16'h3EF0, 4'b0100);
    show(0, SEG_0, 4); blank(1); show(1, SEG_BLANK, 4); blank(1);
    show(2, 7'h49, 4); blank(1); show(3, SEG_3, 4);
    blank(4);

    // 3: too-short strobe and glitching segments must not capture
    v0 = valid_cnt;
    show(0, SEG_5, 2); blank(2);
    for (int k = 0; k < 4; k++) begin
      digit_en = 4'b0001;
      seg_in   = k[0] ? SEG_1 : SEG_0;
      repeat (2) @(posedge clk);
      #1;
    end
    blank(2);
    show(1, SEG_1, 4); show(2, SEG_2, 4); show(3, SEG_3, 4); blank(4);
    check("t3_no_frame_valid", 32'(out_valid), 32'h0);
    check("t3_no_frame_cnt", 32'(valid_cnt - v0), 32'd0);
    push(16'h3219, 4'b0000);
    show(0, SEG_9, 4); blank(4);

    // 4: overflow while held
    out_ready = 1'b0;
    push(16'h8765, 4'b0000);
    show(0, SEG_5, 4); show(1, SEG_6, 4); show(2, SEG_7, 4); show(3, SEG_8, 4); blank(2);
    check("t4_held_valid", 32'(out_valid), 32'h1);
    check("t4_no_ovf_yet", 32'(overflow), 32'h0);
    show(0, SEG_1, 4); show(1, SEG_2, 4); show(2, SEG_3, 4); show(3, SEG_4, 4); blank(2);
    check("t4_ovf", 32'(overflow), 32'h1);
    check("t4_bcd_kept", 32'(bcd_out), 32'h8765);
    check("t4_err_kept", 32'(digit_err), 32'h0);
    check("t4_valid_kept", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("t4_valid_drop", 32'(out_valid), 32'h0);

    // 6: asynchronous reset mid-frame discards partial capture
    show(0, SEG_4, 4); show(1, SEG_5, 4); show(2, SEG_6, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_bcd", 32'(bcd_out), 32'h0);
    check("t6_rst_err", 32'(digit_err), 32'h0);
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_ovf", 32'(overflow), 32'h0);
    digit_en = '0; seg_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    blank(2);
    push(16'h8796, 4'b0000);
    show(2, SEG_7, 4); show(3, SEG_8, 4); show(0, SEG_6, 4); show(1, SEG_9, 4);
    blank(4);

    // 5: completion coincides with accept, no bubble
    out_ready = 1'b0;
    push(16'h1094, 4'b0000);
    push(16'h2E8F, 4'b0100);
    show(0, SEG_4, 4); show(1, SEG_9, 4); show(2, SEG_0, 4); show(3, SEG_1, 4);
    show(0, SEG_BLANK, 4); show(1, SEG_8, 4); show(2, 7'h7E, 4);
    digit_en = 4'b1000; seg_in = SEG_2;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_no_bubble_valid", 32'(out_valid), 32'h1);
    check("t5_no_bubble_bcd", 32'(bcd_out), 32'h2E8F);
    blank(4);
    check("t5_valid_drop", 32'(out_valid), 32'h0);
    check("t5_no_ovf", 32'(overflow), 32'h0);

    blank(4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
